hdlverifier_capture_trigger_ctrl: RTL and testbench

Capture sequencer that consumes the combined trigger from the trigger-combine stage and drives the write side of the capture sample buffer. After an arm request it fills a configurable pre-trigger history, waits for the trigger, records the post-trigger samples, then stops and reports the trigger location and the oldest-sample address. It sits between the trigger combiner and the dual-port capture RAM in the data-capture path.

---
 rtl/hdlverifier_capture_trigger_ctrl_if.sv | 38 +++
 rtl/hdlverifier_capture_trigger_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_hdlverifier_capture_trigger_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/hdlverifier_capture_trigger_ctrl_if.sv
// -----------------------------------------------------------------------------
// hdlverifier_capture_trigger_ctrl_if
// Bundles the control inputs and buffer/status outputs of the capture
// sequencer. clk and reset_n are kept as plain ports on the module.
//   slave  : capture sequencer side (consumes controls, drives buffer/status)
//   master : controlling side (drives controls, observes buffer/status)
// Signals:
//   clk_enable, arm, abort, trigger_in, pretrigger_depth  -> sequencer
//   buf_wr_en, buf_wr_addr, trigger_addr, start_addr,
//   capture_done, state                                   <- sequencer
// -----------------------------------------------------------------------------
interface hdlverifier_capture_trigger_ctrl_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  clk_enable;
    logic                  arm;
    logic                  abort;
    logic                  trigger_in;
    logic [ADDR_WIDTH-1:0] pretrigger_depth;
    logic                  buf_wr_en;
    logic [ADDR_WIDTH-1:0] buf_wr_addr;
    logic [ADDR_WIDTH-1:0] trigger_addr;
    logic [ADDR_WIDTH-1:0] start_addr;
    logic                  capture_done;
    logic [2:0]            state;

    modport slave (
        input  clk_enable, arm, abort, trigger_in, pretrigger_depth,
        output buf_wr_en, buf_wr_addr, trigger_addr, start_addr,
               capture_done, state
    );

    modport master (
        output clk_enable, arm, abort, trigger_in, pretrigger_depth,
        input  buf_wr_en, buf_wr_addr, trigger_addr, start_addr,
               capture_done, state
    );
endinterface

// File: rtl/hdlverifier_capture_trigger_ctrl.sv
// -----------------------------------------------------------------------------
// hdlverifier_capture_trigger_ctrl
// Capture sequencer driving the write side of a 2^ADDR_WIDTH sample buffer.
// After arm it fills P pre-trigger samples, writes freely (wrapping) while
// waiting for the trigger, writes N-P samples starting with the trigger
// sample, then stops and reports the trigger and oldest-sample addresses.
// Ports:
//   clk      capture clock
//   reset_n  asynchronous active-low reset
//   bus      slave modport of hdlverifier_capture_trigger_ctrl_if
// Build option:
//   HDLV_CAPTURE_TRIG_EDGE_EN  when defined, a trigger is a rising edge of
//                              trigger_in instead of a high level.
// -----------------------------------------------------------------------------
module hdlverifier_capture_trigger_ctrl #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic clk,
    input  logic reset_n,
    hdlverifier_capture_trigger_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PREFILL   = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_POST      = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ZERO      = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ONE       = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [ADDR_WIDTH-1:0] r_trig_addr;
    logic [ADDR_WIDTH-1:0] r_start_addr;
    logic                  r_done;
    logic [ADDR_WIDTH-1:0] r_p;
    logic [ADDR_WIDTH-1:0] r_cnt;

    state_t                w_nxt_state;
    logic [ADDR_WIDTH-1:0] w_nxt_wr_addr;
    logic [ADDR_WIDTH-1:0] w_nxt_trig_addr;
    logic [ADDR_WIDTH-1:0] w_nxt_start_addr;
    logic                  w_nxt_done;
    logic [ADDR_WIDTH-1:0] w_nxt_p;
    logic [ADDR_WIDTH-1:0] w_nxt_cnt;
    logic                  w_wr_en;
    logic                  w_trig_hit;

`ifdef HDLV_CAPTURE_TRIG_EDGE_EN
    logic r_trig_prev;

    // Previous trigger level, tracked in every state so a level held across arm never fires
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_trig_prev <= 1'b0;
        end else if (bus.clk_enable) begin
            r_trig_prev <= bus.trigger_in;
        end else begin
            r_trig_prev <= r_trig_prev;
        end
    end

    assign w_trig_hit = bus.trigger_in & ~r_trig_prev;
`else
    assign w_trig_hit = bus.trigger_in;
`endif

    // Next-state and datapath update; nothing moves unless clk_enable is high
    always_comb begin
        w_nxt_state      = r_state;
        w_nxt_wr_addr    = r_wr_addr;
        w_nxt_trig_addr  = r_trig_addr;
        w_nxt_start_addr = r_start_addr;
        w_nxt_done       = r_done;
        w_nxt_p          = r_p;
        w_nxt_cnt        = r_cnt;
        w_wr_en          = 1'b0;

        if (bus.clk_enable) begin
            if (bus.abort) begin
                // Abort suppresses the write on this edge and keeps addresses
                w_nxt_state = ST_IDLE;
                w_nxt_done  = 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE, ST_DONE: begin
                        if (bus.arm) begin
                            w_nxt_wr_addr = ZERO;
                            w_nxt_done    = 1'b0;
                            w_nxt_p       = bus.pretrigger_depth;
                            w_nxt_cnt     = bus.pretrigger_depth;
                            if (bus.pretrigger_depth != ZERO) begin
                                w_nxt_state = ST_PREFILL;
                            end else begin
                                w_nxt_state = ST_WAIT_TRIG;
                            end
                        end else begin
                            w_nxt_state = r_state;
                        end
                    end
                    ST_PREFILL: begin
                        w_wr_en       = 1'b1;
                        w_nxt_wr_addr = r_wr_addr + ONE;
                        w_nxt_cnt     = r_cnt - ONE;
                        if (r_cnt == ONE) begin
                            w_nxt_state = ST_WAIT_TRIG;
                        end else begin
                            w_nxt_state = ST_PREFILL;
                        end
                    end
                    ST_WAIT_TRIG: begin
                        w_wr_en       = 1'b1;
                        w_nxt_wr_addr = r_wr_addr + ONE;
                        if (w_trig_hit) begin
                            w_nxt_trig_addr = r_wr_addr;
                            if (r_p == LAST_ADDR) begin
                                // Trigger sample is the only post sample
                                w_nxt_state      = ST_DONE;
                                w_nxt_done       = 1'b1;
                                w_nxt_start_addr = r_wr_addr + ONE;
                            end else begin
                                // N-P-1 post samples remain; in ADDR_WIDTH bits that is ~P
                                w_nxt_state = ST_POST;
                                w_nxt_cnt   = ~r_p;
                            end
                        end else begin
                            w_nxt_state = ST_WAIT_TRIG;
                        end
                    end
                    ST_POST: begin
                        w_wr_en       = 1'b1;
                        w_nxt_wr_addr = r_wr_addr + ONE;
                        w_nxt_cnt     = r_cnt - ONE;
                        if (r_cnt == ONE) begin
                            // Oldest sample of the window is the next address to be written
                            w_nxt_state      = ST_DONE;
                            w_nxt_done       = 1'b1;
                            w_nxt_start_addr = r_wr_addr + ONE;
                        end else begin
                            w_nxt_state = ST_POST;
                        end
                    end
                    default: begin
                        w_nxt_state = ST_IDLE;
                        w_nxt_done  = 1'b0;
                    end
                endcase
            end
        end else begin
            w_wr_en = 1'b0;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    // Address, count and status registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_addr    <= ZERO;
            r_trig_addr  <= ZERO;
            r_start_addr <= ZERO;
            r_done       <= 1'b0;
            r_p          <= ZERO;
            r_cnt        <= ZERO;
        end else begin
            r_wr_addr    <= w_nxt_wr_addr;
            r_trig_addr  <= w_nxt_trig_addr;
            r_start_addr <= w_nxt_start_addr;
            r_done       <= w_nxt_done;
            r_p          <= w_nxt_p;
            r_cnt        <= w_nxt_cnt;
        end
    end

    assign bus.buf_wr_en    = w_wr_en;
    assign bus.buf_wr_addr  = r_wr_addr;
    assign bus.trigger_addr = r_trig_addr;
    assign bus.start_addr   = r_start_addr;
    assign bus.capture_done = r_done;
    assign bus.state        = r_state;

endmodule

// File: tb/tb_hdlverifier_capture_trigger_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hdlverifier_capture_trigger_ctrl
// Self-checking bench for the capture sequencer with an 8-entry window.
// A reference model tracks the capture as counts of pre samples left,
// whether the trigger was seen and post samples left; expected outputs are
// derived from those counts each cycle.
// -----------------------------------------------------------------------------
module tb_hdlverifier_capture_trigger_ctrl;
    localparam int AW = 3;
    localparam int N  = 1 << AW;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    hdlverifier_capture_trigger_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    hdlverifier_capture_trigger_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // reference model
    bit m_active, m_done, m_trig_seen, m_prev;
    int m_pre_left, m_post_left, m_addr, m_trig, m_start, m_p;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int exp_state();
        if (m_active) begin
            if (m_pre_left > 0) return 1;
            if (!m_trig_seen)   return 2;
            return 3;
        end
        return m_done ? 4 : 0;
    endfunction

    task automatic model_reset();
        m_active = 0; m_done = 0; m_trig_seen = 0; m_prev = 0;
        m_pre_left = 0; m_post_left = 0; m_addr = 0; m_trig = 0; m_start = 0; m_p = 0;
    endtask

    task automatic check_outputs();
        bit exp_wr;
        exp_wr = bus.clk_enable && !bus.abort && m_active;
        check_val("state",        32'(bus.state),        32'(exp_state()));
        check_val("buf_wr_en",    32'(bus.buf_wr_en),    32'(exp_wr));
        check_val("buf_wr_addr",  32'(bus.buf_wr_addr),  32'(m_addr));
        check_val("trigger_addr", 32'(bus.trigger_addr), 32'(m_trig));
        check_val("start_addr",   32'(bus.start_addr),   32'(m_start));
        check_val("capture_done", 32'(bus.capture_done), 32'(m_done));
    endtask

    // advance the model across one clock edge using the inputs now applied
    task automatic model_step();
        bit hit;
`ifdef HDLV_CAPTURE_TRIG_EDGE_EN
        hit = bus.trigger_in && !m_prev;
`else
        hit = bus.trigger_in;
`endif
        if (bus.clk_enable) begin
            if (bus.abort) begin
                m_active = 0;
                m_done   = 0;
            end else if (!m_active) begin
                if (bus.arm) begin
                    m_active    = 1;
                    m_done      = 0;
                    m_addr      = 0;
                    m_p         = int'(bus.pretrigger_depth);
                    m_pre_left  = m_p;
                    m_trig_seen = 0;
                    m_post_left = N - m_p;
                end
            end else begin
                if (m_pre_left > 0) begin
                    m_pre_left--;
                end else if (!m_trig_seen) begin
                    if (hit) begin
                        m_trig_seen = 1;
                        m_trig      = m_addr;
                        m_post_left--;
                    end
                end else begin
                    m_post_left--;
                end
                m_addr = (m_addr + 1) % N;
                if (m_trig_seen && m_post_left == 0) begin
                    m_active = 0;
                    m_done   = 1;
                    m_start  = m_addr;
                end
            end
            m_prev = bus.trigger_in;
        end
    endtask

    task automatic cycle(input bit en, input bit arm, input bit abort, input bit trig, input int p);
        @(negedge clk);
        bus.clk_enable       = en;
        bus.arm              = arm;
        bus.abort            = abort;
        bus.trigger_in       = trig;
        bus.pretrigger_depth = AW'(p);
        #1;
        check_outputs();
        model_step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n        = 1'b0;
        bus.clk_enable = 1'b1;
        bus.arm        = 1'b0;
        bus.abort      = 1'b0;
        bus.trigger_in = 1'b0;
        #1;
        check_val("rst_state",        32'(bus.state),        32'd0);
        check_val("rst_buf_wr_en",    32'(bus.buf_wr_en),    32'd0);
        check_val("rst_buf_wr_addr",  32'(bus.buf_wr_addr),  32'd0);
        check_val("rst_trigger_addr", 32'(bus.trigger_addr), 32'd0);
        check_val("rst_start_addr",   32'(bus.start_addr),   32'd0);
        check_val("rst_capture_done", 32'(bus.capture_done), 32'd0);
        model_reset();
        bus.clk_enable = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // arm with depth p, then pulse the trigger whenever the write address equals target
    task automatic run_capture(input int p, input int target, input bit toggle_en);
        int k;
        cycle(1'b1, 1'b1, 1'b0, 1'b0, p);
        k = 0;
        while (!m_done && k < 200) begin
            cycle(toggle_en ? ((k % 2) == 0) : 1'b1, 1'b0, 1'b0, (m_addr == target), p);
            k++;
        end
        if (!m_done) check_val("capture_timeout", 32'd0, 32'd1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, p);
    endtask

    initial begin
        bus.clk_enable       = 1'b0;
        bus.arm              = 1'b0;
        bus.abort            = 1'b0;
        bus.trigger_in       = 1'b0;
        bus.pretrigger_depth = '0;
        model_reset();
        do_reset();

        // P=3, trigger on the write to addr 6
        run_capture(3, 6, 1'b0);
        check_val("p3_trigger_addr", 32'(bus.trigger_addr), 32'd6);
        check_val("p3_start_addr",   32'(bus.start_addr),   32'd3);
        check_val("p3_capture_done", 32'(bus.capture_done), 32'd1);

        // same capture with clk_enable alternating
        run_capture(3, 6, 1'b1);
        check_val("p3en_trigger_addr", 32'(bus.trigger_addr), 32'd6);
        check_val("p3en_start_addr",   32'(bus.start_addr),   32'd3);

        // P=0 trigger at first write; P=7 trigger at addr 7
        run_capture(0, 0, 1'b0);
        check_val("p0_trigger_addr", 32'(bus.trigger_addr), 32'd0);
        check_val("p0_start_addr",   32'(bus.start_addr),   32'd0);
        run_capture(7, 7, 1'b0);
        check_val("p7_trigger_addr", 32'(bus.trigger_addr), 32'd7);
        check_val("p7_start_addr",   32'(bus.start_addr),   32'd0);

        // P=4 with trigger held high from arm onward
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 4);
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1, 4);
`ifdef HDLV_CAPTURE_TRIG_EDGE_EN
        check_val("edge_held_no_trig", 32'(bus.state), 32'd2);
`else
        check_val("lvl_trigger_addr", 32'(bus.trigger_addr), 32'd4);
        check_val("lvl_start_addr",   32'(bus.start_addr),   32'd0);
`endif
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 4);
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1, 4);
        check_val("p4_done", 32'(bus.capture_done), 32'd1);

        // abort during POST, then re-arm
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 2);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, (m_addr == 3), 2);
        check_val("abort_pre_state", 32'(bus.state), 32'd3);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 2);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 2);
        check_val("abort_state", 32'(bus.state),        32'd0);
        check_val("abort_done",  32'(bus.capture_done), 32'd0);
        run_capture(1, 5, 1'b0);

        // reset in the middle of POST
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, (m_addr == 2), 1);
        do_reset();

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 39) == 0, $urandom_range(0, 5) == 0,
                  int'($urandom_range(0, N - 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
